// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file writeback commit unit.
// A FIFO entry carries {dest, val, exc, pc, addr}, MSB first.
package wb_pkg;
   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;
   localparam int WB_DEPTH  = 2;

   typedef struct packed {
      logic [WB_REG_AW-1:0] dest;
      logic [WB_DATA_W-1:0] val;
      logic                 exc;
      logic [WB_DATA_W-1:0] pc;
      logic [WB_DATA_W-1:0] addr;
   } wb_entry_t;

   typedef enum logic {ST_RUN, ST_HOLD} wb_state_t;
endpackage

// File: rtl/wb_src_fifo.sv
// Per-source completion FIFO: DEPTH entries, flush clears count and pointers.
// Flush dominates push/pop; the caller only pushes when count < DEPTH.
module wb_src_fifo
   import wb_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_push_dat,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [W-1:0]             o_head
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;

   // Storage carries no reset; count and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit: buffers ALU/MEM completions, MEM-first one write per cycle, faults flush and HOLD.
// Optional WB_R0_ZERO_EN: normal pops targeting r0 are consumed without asserting wb_en.
module wb_commit_unit
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW,
   parameter int DEPTH  = WB_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_val,
   input  logic              alu_exc,
   input  logic [DATA_W-1:0] alu_pc,
   input  logic [DATA_W-1:0] alu_addr,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_val,
   input  logic              mem_exc,
   input  logic [DATA_W-1:0] mem_pc,
   input  logic [DATA_W-1:0] mem_addr,
   input  logic              exc_clear,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_val,
   output logic              exc_v,
   output logic [DATA_W-1:0] exc_pc,
   output logic [DATA_W-1:0] exc_addr,
   output logic              busy
);
   localparam int EW = REG_AW + 3*DATA_W + 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   wb_state_t         r_state;
   logic              r_wb_en, r_exc_v;
   logic [REG_AW-1:0] r_wb_dest;
   logic [DATA_W-1:0] r_wb_val, r_exc_pc, r_exc_addr;

   logic [CW-1:0] w_alu_cnt, w_mem_cnt;
   logic [EW-1:0] w_alu_head, w_mem_head, w_head;
   logic          w_run, w_alu_push, w_mem_push, w_pop_alu, w_pop_mem, w_pop_any;
   logic          w_flush, w_wr_ok;

   assign w_run      = (r_state == ST_RUN);
   assign alu_ready  = w_run && (w_alu_cnt < FULL);
   assign mem_ready  = w_run && (w_mem_cnt < FULL);
   assign w_alu_push = alu_valid && alu_ready;
   assign w_mem_push = mem_valid && mem_ready;

   // MEM is the older pipeline, so its head always drains first.
   assign w_pop_mem = w_run && (w_mem_cnt != '0);
   assign w_pop_alu = w_run && !w_pop_mem && (w_alu_cnt != '0);
   assign w_pop_any = w_pop_mem || w_pop_alu;
   assign w_head    = w_pop_mem ? w_mem_head : w_alu_head;
   assign w_flush   = w_pop_any && w_head[2*DATA_W];

`ifdef WB_R0_ZERO_EN
   assign w_wr_ok = (w_head[EW-1 -: REG_AW] != '0);
`else
   assign w_wr_ok = 1'b1;
`endif

   wb_src_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_alu_push),
      .i_push_dat ({alu_dest, alu_val, alu_exc, alu_pc, alu_addr}),
      .i_pop      (w_pop_alu),
      .i_flush    (w_flush),
      .o_count    (w_alu_cnt),
      .o_head     (w_alu_head)
   );

   wb_src_fifo #(.W(EW), .DEPTH(DEPTH)) u_mem_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_mem_push),
      .i_push_dat ({mem_dest, mem_val, mem_exc, mem_pc, mem_addr}),
      .i_pop      (w_pop_mem),
      .i_flush    (w_flush),
      .o_count    (w_mem_cnt),
      .o_head     (w_mem_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_wb_en    <= 1'b0;
         r_wb_dest  <= '0;
         r_wb_val   <= '0;
         r_exc_v    <= 1'b0;
         r_exc_pc   <= '0;
         r_exc_addr <= '0;
      end else begin
         r_wb_en <= 1'b0;
         r_exc_v <= 1'b0;
         if (w_pop_any) begin
            if (w_head[2*DATA_W]) begin
               r_exc_v    <= 1'b1;
               r_exc_pc   <= w_head[2*DATA_W-1 -: DATA_W];
               r_exc_addr <= w_head[DATA_W-1:0];
               r_state    <= ST_HOLD;
            end else if (w_wr_ok) begin
               r_wb_en   <= 1'b1;
               r_wb_dest <= w_head[EW-1 -: REG_AW];
               r_wb_val  <= w_head[3*DATA_W -: DATA_W];
            end
         end else if (r_state == ST_HOLD && exc_clear) begin
            r_state <= ST_RUN;
         end
      end
   end

   assign wb_en    = r_wb_en;
   assign wb_dest  = r_wb_dest;
   assign wb_val   = r_wb_val;
   assign exc_v    = r_exc_v;
   assign exc_pc   = r_exc_pc;
   assign exc_addr = r_exc_addr;
   assign busy     = (w_alu_cnt != '0) || (w_mem_cnt != '0) || (r_state == ST_HOLD);
endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: expected writes/exceptions queued at drive time, checked at negedge.
module tb_wb_commit_unit;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 0, mem_valid = 0, alu_exc = 0, mem_exc = 0, exc_clear = 0;
   logic [4:0]  alu_dest = 0, mem_dest = 0;
   logic [31:0] alu_val = 0, alu_pc = 0, alu_addr = 0;
   logic [31:0] mem_val = 0, mem_pc = 0, mem_addr = 0;
   logic        alu_ready, mem_ready, wb_en, exc_v, busy;
   logic [4:0]  wb_dest;
   logic [31:0] wb_val, exc_pc, exc_addr;

   int n_cmp = 0;
   int n_err = 0;
   bit sb_en = 1'b1;
   wb_entry_t q_wr[$];
   wb_entry_t q_exc[$];

   always #5 clk = ~clk;

   wb_commit_unit dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_val(alu_val),
      .alu_exc(alu_exc), .alu_pc(alu_pc), .alu_addr(alu_addr),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_val(mem_val),
      .mem_exc(mem_exc), .mem_pc(mem_pc), .mem_addr(mem_addr),
      .exc_clear(exc_clear),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
      .exc_v(exc_v), .exc_pc(exc_pc), .exc_addr(exc_addr), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic wb_entry_t mk_wr(input logic [4:0] d, input logic [31:0] v);
      wb_entry_t e;
      e = '0;
      e.dest = d;
      e.val  = v;
      return e;
   endfunction

   function automatic wb_entry_t mk_exc(input logic [31:0] pc, input logic [31:0] ad);
      wb_entry_t e;
      e = '0;
      e.exc  = 1'b1;
      e.pc   = pc;
      e.addr = ad;
      return e;
   endfunction

   // Scoreboard: every write or exception pulse must match the head of its queue.
   always @(negedge clk) begin
      if (sb_en && !rst) begin
         if (wb_en) begin
            if (q_wr.size() == 0) chk("unexpected_write", {27'd0, wb_dest, wb_val}, 64'd0);
            else begin
               wb_entry_t e;
               e = q_wr.pop_front();
               chk("wb_dest", 64'(wb_dest), 64'(e.dest));
               chk("wb_val", 64'(wb_val), 64'(e.val));
            end
         end
         if (exc_v) begin
            chk("exc_no_write", 64'(wb_en), 64'd0);
            if (q_exc.size() == 0) chk("unexpected_exc", 64'(exc_pc), 64'd0);
            else begin
               wb_entry_t e;
               e = q_exc.pop_front();
               chk("exc_pc", 64'(exc_pc), 64'(e.pc));
               chk("exc_addr", 64'(exc_addr), 64'(e.addr));
            end
         end
      end
   end

   // Both senders are entered 1 time unit after a rising edge and return likewise.
   task automatic send_alu(input logic [4:0] d, input logic [31:0] v, input logic e,
                           input logic [31:0] pc, input logic [31:0] ad);
      int  n = 0;
      logic acc = 1'b0;
      alu_valid = 1; alu_dest = d; alu_val = v; alu_exc = e; alu_pc = pc; alu_addr = ad;
      while (!acc && n < 200) begin
         @(negedge clk); acc = alu_ready;
         @(posedge clk); n++;
      end
      if (!acc) chk("alu_accept_timeout", 64'd0, 64'd1);
      #1 alu_valid = 0;
   endtask

   task automatic send_mem(input logic [4:0] d, input logic [31:0] v, input logic e,
                           input logic [31:0] pc, input logic [31:0] ad);
      int  n = 0;
      logic acc = 1'b0;
      mem_valid = 1; mem_dest = d; mem_val = v; mem_exc = e; mem_pc = pc; mem_addr = ad;
      while (!acc && n < 200) begin
         @(negedge clk); acc = mem_ready;
         @(posedge clk); n++;
      end
      if (!acc) chk("mem_accept_timeout", 64'd0, 64'd1);
      #1 mem_valid = 0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((busy || q_wr.size() != 0) && n < 100) begin
         @(negedge clk); n++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_wr_left"}, 64'(q_wr.size()), 64'd0);
      chk({tag, "_exc_left"}, 64'(q_exc.size()), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_wb_en", 64'(wb_en), 64'd0);
      chk("rst_exc_v", 64'(exc_v), 64'd0);
      chk("rst_wb_dest", 64'(wb_dest), 64'd0);
      chk("rst_wb_val", 64'(wb_val), 64'd0);
      chk("rst_exc_pc", 64'(exc_pc), 64'd0);
      chk("rst_exc_addr", 64'(exc_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd1);
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);
      @(posedge clk); #1;

      // Single ALU write: two cycles from accept to write.
      q_wr.push_back(mk_wr(5'd3, 32'hDEADBEEF));
      send_alu(5'd3, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("lat_early_wb_en", 64'(wb_en), 64'd0);
      chk("lat_busy_queued", 64'(busy), 64'd1);
      @(negedge clk);
      chk("lat_wb_en", 64'(wb_en), 64'd1);
      chk("lat_busy_after_pop", 64'(busy), 64'd0);
      drain("single");

      // Simultaneous sources: MEM first.
      q_wr.push_back(mk_wr(5'd2, 32'h22));
      q_wr.push_back(mk_wr(5'd1, 32'h11));
      fork
         send_alu(5'd1, 32'h11, 1'b0, 32'h0, 32'h0);
         send_mem(5'd2, 32'h22, 1'b0, 32'h0, 32'h0);
      join
      drain("simul");

      // Backpressure: MEM streams 4, ALU fills and stalls.
      for (int i = 0; i < 4; i++) q_wr.push_back(mk_wr(5'(8 + i), 32'hA000 + 32'(i)));
      for (int i = 0; i < 4; i++) q_wr.push_back(mk_wr(5'(16 + i), 32'hB000 + 32'(i)));
      fork
         for (int i = 0; i < 4; i++) send_mem(5'(8 + i), 32'hA000 + 32'(i), 1'b0, 32'h0, 32'h0);
         for (int j = 0; j < 4; j++) send_alu(5'(16 + j), 32'hB000 + 32'(j), 1'b0, 32'h0, 32'h0);
         begin
            repeat (3) @(negedge clk);
            chk("bp_alu_ready_full", 64'(alu_ready), 64'd0);
         end
      join
      drain("bp");

      // Exception: MEM fault with an ALU entry to r5 queued behind it.
      q_exc.push_back(mk_exc(32'h100, 32'h2004));
      fork
         send_mem(5'd7, 32'h77, 1'b1, 32'h100, 32'h2004);
         send_alu(5'd5, 32'h55, 1'b0, 32'h0, 32'h0);
      join
      @(negedge clk);
      @(negedge clk);
      chk("hold_alu_ready", 64'(alu_ready), 64'd0);
      chk("hold_mem_ready", 64'(mem_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      chk("hold_alu_ready_late", 64'(alu_ready), 64'd0);
      chk("hold_exc_pc_kept", 64'(exc_pc), 64'h100);
      chk("hold_exc_addr_kept", 64'(exc_addr), 64'h2004);
      @(posedge clk); #1 exc_clear = 1;
      @(posedge clk); #1 exc_clear = 0;
      @(negedge clk);
      chk("clear_alu_ready", 64'(alu_ready), 64'd1);
      chk("clear_mem_ready", 64'(mem_ready), 64'd1);
      chk("clear_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 exc_clear = 1;
      @(posedge clk); #1 exc_clear = 0;
      @(negedge clk);
      chk("clear_in_run_ready", 64'(alu_ready), 64'd1);
      @(posedge clk); #1;
      drain("exc");

      // Reset mid-stream: outputs before reset are not scored.
      sb_en = 1'b0;
      alu_valid = 1; alu_exc = 0; mem_valid = 1; mem_exc = 0;
      for (int i = 0; i < 3; i++) begin
         alu_dest = 5'(20 + i); alu_val = 32'hC0 + 32'(i);
         mem_dest = 5'(24 + i); mem_val = 32'hD0 + 32'(i);
         @(posedge clk); #1;
      end
      rst = 1;
      @(posedge clk); #1;
      rst = 0; alu_valid = 0; mem_valid = 0;
      @(negedge clk);
      chk("mrst_wb_en", 64'(wb_en), 64'd0);
      chk("mrst_exc_v", 64'(exc_v), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_alu_ready", 64'(alu_ready), 64'd1);
      chk("mrst_mem_ready", 64'(mem_ready), 64'd1);
      q_wr.delete();
      q_exc.delete();
      sb_en = 1'b1;
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
      drain("mrst");

      // Write to r0.
`ifndef WB_R0_ZERO_EN
      q_wr.push_back(mk_wr(5'd0, 32'd7));
`endif
      send_alu(5'd0, 32'd7, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
`ifdef WB_R0_ZERO_EN
      chk("r0_wb_en", 64'(wb_en), 64'd0);
`else
      chk("r0_wb_en", 64'(wb_en), 64'd1);
`endif
      drain("r0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
